arm7tdmi_mul_sequencer: RTL
===========================

// Module: arm7tdmi_mul_sequencer
// PURPOSE
//   Execute-stage issue/writeback controller: the initiator side of the arm7tdmi_multiply interface.
//   Accepts one decoded MUL/MLA/UMULL/SMULL/UMLAL/SMLAL op, drives the multiply unit for one cycle,
//   holds the pipeline for the ARM7TDMI internal-cycle count, then writes RdLo/RdHi and N/Z flags.
// PARAMETERS
//   EARLY_TERM  1  1: m from Rs early-termination rule; 0: m fixed at FIXED_M
//   FIXED_M     4  m used when EARLY_TERM=0 (range 1..4)
// PORTS
//   clk             in   1   clock
//   rst             in   1   synchronous active-high reset
//   flush           in   1   abort current op (branch/exception flush)
//   issue_valid     in   1   op presented
//   issue_ready     out  1   sequencer idle; op accepted when valid&ready
//   op_long         in   1   64-bit result (xMULL/xMLAL)
//   op_signed       in   1   signed long op
//   op_acc          in   1   accumulate (MLA/xMLAL)
//   op_setflags     in   1   S bit
//   rd_lo_idx       in   4   dest Rd (short) / RdLo (long)
//   rd_hi_idx       in   4   dest RdHi (long only)
//   rm_val          in   32  Rm operand
//   rs_val          in   32  Rs operand (drives m)
//   acc_lo_val      in   32  Rn (MLA) / RdLo (MLAL)
//   acc_hi_val      in   32  RdHi (MLAL)
//   mul_en          out  1   one-cycle start to multiply unit
//   mul_long, mul_signed, mul_accumulate, mul_set_flags  out 1 each  latched op bits
//   mul_type        out  2   00 MUL, 01 MLA, 10 xMULL, 11 xMLAL
//   operand_a       out  32  latched rm_val
//   operand_b       out  32  latched rs_val
//   acc_hi, acc_lo  out  32  latched accumulator values
//   result_hi, result_lo  in 32  multiply results
//   result_ready    in   1   results valid
//   negative, zero  in   1   multiply-unit N/Z
//   stall           out  1   high whenever state != IDLE
//   wb_en           out  1   register write strobe
//   wb_idx          out  4   register index
//   wb_data         out  32  register data
//   flag_we         out  1   N/Z write strobe (C,V untouched)
//   flag_n, flag_z  out  1   flag values
// BEHAVIOUR
//   Reset: all outputs 0 (issue_ready 0 while rst high, 1 the cycle after); state IDLE.
//   All outputs registered. States: IDLE -> EXEC -> WB_LO -> [WB_HI] -> IDLE.
//   IDLE: issue_ready=1; on valid&ready latch all op fields, compute I, go EXEC.
//   m (EARLY_TERM=1): Rs[31:8] all-0 ->1, Rs[31:16] ->2, Rs[31:24] ->3, else 4; all-1 patterns
//     also count for MUL/MLA/SMULL/SMLAL; UMULL/UMLAL use all-0 only.
//   I = m + op_acc + op_long (1..6). EXEC lasts max(I, cycles until result_ready) cycles.
//   mul_en=1 in first EXEC cycle only; mul_* and operand outputs stable for all of EXEC.
//   First cycle with result_ready=1 in EXEC: capture result_hi/lo, negative, zero; later ignored.
//   WB_LO: wb_en=1, wb_idx=rd_lo_idx, wb_data=result_lo. Short op: flag_we=op_setflags here.
//   WB_HI (long only): wb_en=1, wb_idx=rd_hi_idx, wb_data=result_hi, flag_we=op_setflags.
//   flag_n=captured negative; flag_z=captured zero (64-bit zero for long).
//   rd_hi_idx==rd_lo_idx: both written in order; RdHi value persists.
//   flush: any state -> IDLE next cycle; wb_en/flag_we/mul_en 0 from that cycle; capture discarded.
//   flush and issue_valid same IDLE cycle: flush wins, op not accepted.
//   rst mid-op: identical to flush plus all outputs to reset values.
//   Accept-to-ready latency (result_ready prompt) = I + 1 (short) / I + 2 (long) + 1 cycles.
// TESTING
//   MUL rm=5 rs=7 S=1 -> I=1; wb r[rd_lo]=35; flag_n=0 z=0; issue_ready back 3 cycles after accept.
//   UMULL rm=rs=FFFFFFFF -> m=4, I=5; wb lo=00000001 then hi=FFFFFFFE; ready 8 cycles after accept.
//   SMULL rm=rs=FFFFFFFF -> m=1, I=2; wb lo=00000001, hi=00000000; flag_z=0.
//   MUL rm=0 rs=42 S=1 -> wb 0, flag_we=1, flag_z=1; MLA 3*4+2 S=0 -> wb 14, flag_we=0.
//   UMLAL, flush on 2nd EXEC cycle -> no wb_en/flag_we pulses; issue_ready=1 next cycle.
//   MUL rs=7, stub holds result_ready low 4 cycles -> EXEC extends; WB_LO cycle after result_ready.

Source files
------------

// File: rtl/arm7tdmi_mul_sequencer.sv
// Execute-stage issue/writeback controller for the ARM7TDMI multiplier: issues one op,
// holds the pipeline for the internal-cycle count, then writes RdLo/RdHi and N/Z.
module arm7tdmi_mul_sequencer #(
  parameter int EARLY_TERM = 1,
  parameter int FIXED_M    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic        op_long,
  input  logic        op_signed,
  input  logic        op_acc,
  input  logic        op_setflags,
  input  logic [3:0]  rd_lo_idx,
  input  logic [3:0]  rd_hi_idx,
  input  logic [31:0] rm_val,
  input  logic [31:0] rs_val,
  input  logic [31:0] acc_lo_val,
  input  logic [31:0] acc_hi_val,
  output logic        mul_en,
  output logic        mul_long,
  output logic        mul_signed,
  output logic        mul_accumulate,
  output logic        mul_set_flags,
  output logic [1:0]  mul_type,
  output logic [31:0] operand_a,
  output logic [31:0] operand_b,
  output logic [31:0] acc_hi,
  output logic [31:0] acc_lo,
  input  logic [31:0] result_hi,
  input  logic [31:0] result_lo,
  input  logic        result_ready,
  input  logic        negative,
  input  logic        zero,
  output logic        stall,
  output logic        wb_en,
  output logic [3:0]  wb_idx,
  output logic [31:0] wb_data,
  output logic        flag_we,
  output logic        flag_n,
  output logic        flag_z
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    WB_LO = 2'd2,
    WB_HI = 2'd3
  } state_t;

  state_t      state_r;
  logic [2:0]  icnt_r;
  logic [2:0]  cyc_r;
  logic        got_r;
  logic [31:0] res_hi_r;
  logic [31:0] res_lo_r;
  logic        neg_r;
  logic        zero_r;
  logic [3:0]  rd_lo_r;
  logic [3:0]  rd_hi_r;

  logic        sign_ok_s;
  logic [2:0]  m_s;
  logic [2:0]  i_s;
  logic        done_s;
  logic [31:0] cap_lo_s;
  logic        cap_neg_s;
  logic        cap_zero_s;

  // Early-termination m from Rs; all-ones upper bytes only terminate for signed interpretations.
  always_comb begin
    sign_ok_s = op_signed | ~op_long;
    m_s       = 3'd4;
    if (EARLY_TERM != 0) begin
      if ((rs_val[31:8] == 24'h000000) || (sign_ok_s && (rs_val[31:8] == 24'hFFFFFF))) begin
        m_s = 3'd1;
      end else if ((rs_val[31:16] == 16'h0000) || (sign_ok_s && (rs_val[31:16] == 16'hFFFF))) begin
        m_s = 3'd2;
      end else if ((rs_val[31:24] == 8'h00) || (sign_ok_s && (rs_val[31:24] == 8'hFF))) begin
        m_s = 3'd3;
      end else begin
        m_s = 3'd4;
      end
    end else begin
      m_s = 3'(FIXED_M);
    end
    i_s = m_s + {2'b00, op_acc} + {2'b00, op_long};
  end

  // Leave EXEC once the internal-cycle count has elapsed and a result has arrived.
  always_comb begin
    done_s     = (got_r | result_ready) & (cyc_r >= icnt_r);
    cap_lo_s   = got_r ? res_lo_r : result_lo;
    cap_neg_s  = got_r ? neg_r : negative;
    cap_zero_s = got_r ? zero_r : zero;
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      icnt_r         <= 3'd0;
      cyc_r          <= 3'd0;
      got_r          <= 1'b0;
      res_hi_r       <= 32'd0;
      res_lo_r       <= 32'd0;
      neg_r          <= 1'b0;
      zero_r         <= 1'b0;
      rd_lo_r        <= 4'd0;
      rd_hi_r        <= 4'd0;
      issue_ready    <= 1'b0;
      mul_en         <= 1'b0;
      mul_long       <= 1'b0;
      mul_signed     <= 1'b0;
      mul_accumulate <= 1'b0;
      mul_set_flags  <= 1'b0;
      mul_type       <= 2'b00;
      operand_a      <= 32'd0;
      operand_b      <= 32'd0;
      acc_hi         <= 32'd0;
      acc_lo         <= 32'd0;
      stall          <= 1'b0;
      wb_en          <= 1'b0;
      wb_idx         <= 4'd0;
      wb_data        <= 32'd0;
      flag_we        <= 1'b0;
      flag_n         <= 1'b0;
      flag_z         <= 1'b0;
    end else begin
      mul_en  <= 1'b0;
      wb_en   <= 1'b0;
      flag_we <= 1'b0;
      if (flush) begin
        state_r     <= IDLE;
        got_r       <= 1'b0;
        issue_ready <= 1'b1;
        stall       <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            issue_ready <= 1'b1;
            if (issue_valid && issue_ready) begin
              state_r        <= EXEC;
              icnt_r         <= i_s;
              cyc_r          <= 3'd1;
              got_r          <= 1'b0;
              rd_lo_r        <= rd_lo_idx;
              rd_hi_r        <= rd_hi_idx;
              mul_long       <= op_long;
              mul_signed     <= op_signed;
              mul_accumulate <= op_acc;
              mul_set_flags  <= op_setflags;
              mul_type       <= {op_long, op_acc};
              operand_a      <= rm_val;
              operand_b      <= rs_val;
              acc_hi         <= acc_hi_val;
              acc_lo         <= acc_lo_val;
              mul_en         <= 1'b1;
              issue_ready    <= 1'b0;
              stall          <= 1'b1;
            end
          end
          EXEC: begin
            if (!got_r && result_ready) begin
              got_r    <= 1'b1;
              res_hi_r <= result_hi;
              res_lo_r <= result_lo;
              neg_r    <= negative;
              zero_r   <= zero;
            end
            if (done_s) begin
              state_r <= WB_LO;
              wb_en   <= 1'b1;
              wb_idx  <= rd_lo_r;
              wb_data <= cap_lo_s;
              if (!mul_long && mul_set_flags) begin
                flag_we <= 1'b1;
                flag_n  <= cap_neg_s;
                flag_z  <= cap_zero_s;
              end
            end else if (cyc_r != 3'd7) begin
              cyc_r <= cyc_r + 3'd1;
            end
          end
          WB_LO: begin
            if (mul_long) begin
              state_r <= WB_HI;
              wb_en   <= 1'b1;
              wb_idx  <= rd_hi_r;
              wb_data <= res_hi_r;
              if (mul_set_flags) begin
                flag_we <= 1'b1;
                flag_n  <= neg_r;
                flag_z  <= zero_r;
              end
            end else begin
              state_r     <= IDLE;
              got_r       <= 1'b0;
              issue_ready <= 1'b1;
              stall       <= 1'b0;
            end
          end
          WB_HI: begin
            state_r     <= IDLE;
            got_r       <= 1'b0;
            issue_ready <= 1'b1;
            stall       <= 1'b0;
          end
          default: begin
            state_r     <= IDLE;
            got_r       <= 1'b0;
            issue_ready <= 1'b1;
            stall       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
